// File: rtl/trigger_frame_decoder.sv
// trigger_frame_decoder
//   Consumes the 64-bit triggered-frame stream coming from the trigger block.
//   Each frame is a header, LEN data words and a footer. The decoder unpacks
//   the data words into ADC samples on a valid/ready output. It also reports
//   per-frame metadata and keeps a saturating error count.
//
// Ports
//   RD_CLK, RD_RESET     clock, synchronous active-high reset
//   DIN, iVALID, oREADY  frame word input handshake
//   oSAMPLES             SAMPLE_PER_WORD samples, lane k at [k*RES +: RES]
//   oSAMPLE_VALID/iSAMPLE_READY/oSAMPLE_LAST  sample output handshake
//   oFRAME_DONE          one-cycle pulse after a footer is accepted
//   oCHANNEL_ID, oTIME_STAMP, oFRAME_LEN, oFRAME_ERR  metadata of the last frame
//   oERR_CNT             saturating count of dropped words and bad footers
//   oBUSY                decoder is inside a frame
module trigger_frame_decoder #(
    parameter int          DIN_WIDTH              = 64,
    parameter int          ADC_RESOLUTION_WIDTH   = 12,
    parameter int          SAMPLE_PER_WORD        = 4,
    parameter int          TIME_STAMP_WIDTH       = 48,
    parameter int          FIRST_TIME_STAMP_WIDTH = 32,
    parameter int          MAX_FRAME_LENGTH       = 50,
    parameter logic [7:0]  HEADER_ID              = 8'hAA,
    parameter logic [7:0]  FOOTER_ID              = 8'h55
) (
    input  logic                                              RD_CLK,
    input  logic                                              RD_RESET,
    input  logic [DIN_WIDTH-1:0]                              DIN,
    input  logic                                              iVALID,
    output logic                                              oREADY,
    output logic [SAMPLE_PER_WORD*ADC_RESOLUTION_WIDTH-1:0]   oSAMPLES,
    output logic                                              oSAMPLE_VALID,
    input  logic                                              iSAMPLE_READY,
    output logic                                              oSAMPLE_LAST,
    output logic                                              oFRAME_DONE,
    output logic [7:0]                                        oCHANNEL_ID,
    output logic [TIME_STAMP_WIDTH-1:0]                       oTIME_STAMP,
    output logic [7:0]                                        oFRAME_LEN,
    output logic                                              oFRAME_ERR,
    output logic [15:0]                                       oERR_CNT,
    output logic                                              oBUSY
);

    localparam int LANE_W = 16;
    localparam int SAMP_W = SAMPLE_PER_WORD * ADC_RESOLUTION_WIDTH;
    localparam int TS_HI_W = TIME_STAMP_WIDTH - FIRST_TIME_STAMP_WIDTH;

    typedef enum logic [1:0] {IDLE, DATA, FOOTER} state_t;

    state_t                              state_reg, state_next;
    logic [7:0]                          chan_reg;
    logic [7:0]                          len_reg;
    logic [FIRST_TIME_STAMP_WIDTH-1:0]   ts_lo_reg;
    logic [7:0]                          word_cnt_reg;
    logic [SAMP_W-1:0]                   samples_reg;
    logic                                sample_valid_reg;
    logic                                sample_last_reg;
    logic                                frame_done_reg;
    logic [7:0]                          channel_id_reg;
    logic [TIME_STAMP_WIDTH-1:0]         time_stamp_reg;
    logic [7:0]                          frame_len_reg;
    logic                                frame_err_reg;
    logic [15:0]                         err_cnt_reg;

    logic              ready;
    logic              busy;
    logic              xfer;
    logic              hdr_ok;
    logic              ftr_ok;
    logic              last_word;
    logic              err_inc;
    logic [7:0]        hdr_len;
    logic [SAMP_W-1:0] samples_next;

    // Each 16-bit lane carries its sample left-justified; the low bits are dropped.
    generate
        for (genvar gi = 0; gi < SAMPLE_PER_WORD; gi++) begin : g_unpack
            assign samples_next[gi*ADC_RESOLUTION_WIDTH +: ADC_RESOLUTION_WIDTH] =
                DIN[gi*LANE_W + LANE_W - 1 -: ADC_RESOLUTION_WIDTH];
        end
    endgenerate

    assign hdr_len   = DIN[47:40];
    assign hdr_ok    = (DIN[63:56] == HEADER_ID) && (hdr_len != 8'd0) &&
                       (hdr_len <= 8'(MAX_FRAME_LENGTH));
    assign ftr_ok    = (DIN[63:56] == FOOTER_ID) && (DIN[55:48] == chan_reg);
    assign last_word = ((word_cnt_reg + 8'd1) == len_reg);
    assign xfer      = iVALID && ready;

    // Header rejects in IDLE and bad footers are the only error sources,
    // so the counter can step at most once per cycle.
    assign err_inc = xfer && (((state_reg == IDLE) && !hdr_ok) ||
                              ((state_reg == FOOTER) && !ftr_ok));

    // State register
    always_ff @(posedge RD_CLK) begin
        if (RD_RESET) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (xfer && hdr_ok)    state_next = DATA;
            DATA:    if (xfer && last_word) state_next = FOOTER;
            FOOTER:  if (xfer)              state_next = IDLE;
            default:                        state_next = IDLE;
        endcase
    end

    // State-decoded outputs. In DATA the input stalls only while a sample is
    // held and the consumer is not taking it, so accept+drain has no bubble.
    always_comb begin
        ready = 1'b0;
        busy  = 1'b0;
        case (state_reg)
            IDLE:    ready = 1'b1;
            DATA:    begin
                ready = !sample_valid_reg || iSAMPLE_READY;
                busy  = 1'b1;
            end
            FOOTER:  begin
                ready = 1'b1;
                busy  = 1'b1;
            end
            default: ready = 1'b0;
        endcase
        if (RD_RESET) begin
            ready = 1'b0;
        end
    end

    // Datapath
    always_ff @(posedge RD_CLK) begin
        if (RD_RESET) begin
            chan_reg         <= '0;
            len_reg          <= '0;
            ts_lo_reg        <= '0;
            word_cnt_reg     <= '0;
            samples_reg      <= '0;
            sample_valid_reg <= 1'b0;
            sample_last_reg  <= 1'b0;
            frame_done_reg   <= 1'b0;
            channel_id_reg   <= '0;
            time_stamp_reg   <= '0;
            frame_len_reg    <= '0;
            frame_err_reg    <= 1'b0;
            err_cnt_reg      <= '0;
        end else begin
            if (xfer && (state_reg == IDLE) && hdr_ok) begin
                chan_reg     <= DIN[55:48];
                len_reg      <= hdr_len;
                ts_lo_reg    <= DIN[FIRST_TIME_STAMP_WIDTH-1:0];
                word_cnt_reg <= '0;
            end

            if (xfer && (state_reg == DATA)) begin
                samples_reg      <= samples_next;
                sample_valid_reg <= 1'b1;
                sample_last_reg  <= last_word;
                word_cnt_reg     <= word_cnt_reg + 8'd1;
            end else if (iSAMPLE_READY) begin
                sample_valid_reg <= 1'b0;
                sample_last_reg  <= 1'b0;
            end

            frame_done_reg <= xfer && (state_reg == FOOTER);
            if (xfer && (state_reg == FOOTER)) begin
                channel_id_reg <= chan_reg;
                time_stamp_reg <= {DIN[FIRST_TIME_STAMP_WIDTH +: TS_HI_W], ts_lo_reg};
                frame_len_reg  <= len_reg;
                frame_err_reg  <= !ftr_ok;
            end

            if (err_inc && (err_cnt_reg != 16'hFFFF)) begin
                err_cnt_reg <= err_cnt_reg + 16'd1;
            end
        end
    end

    assign oREADY        = ready;
    assign oBUSY         = busy;
    assign oSAMPLES      = samples_reg;
    assign oSAMPLE_VALID = sample_valid_reg;
    assign oSAMPLE_LAST  = sample_last_reg;
    assign oFRAME_DONE   = frame_done_reg;
    assign oCHANNEL_ID   = channel_id_reg;
    assign oTIME_STAMP   = time_stamp_reg;
    assign oFRAME_LEN    = frame_len_reg;
    assign oFRAME_ERR    = frame_err_reg;
    assign oERR_CNT      = err_cnt_reg;

endmodule

// File: tb/tb_trigger_frame_decoder.sv
// tb_trigger_frame_decoder
//   Directed bench for trigger_frame_decoder. Frames are built from a small
//   table of data words whose unpacked samples were worked out by hand. A
//   negedge monitor records every sample handshake and every oFRAME_DONE.
//   Each frame's records are then compared against the table and against
//   the metadata written into each test step.
module tb_trigger_frame_decoder;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] din;
    logic        ivalid;
    logic        oready;
    logic [47:0] osamp;
    logic        osv;
    logic        isr = 1'b1;
    logic        olast;
    logic        odone;
    logic [7:0]  ochan;
    logic [47:0] ots;
    logic [7:0]  olen;
    logic        oerr;
    logic [15:0] oerrcnt;
    logic        obusy;

    always #5 clk = ~clk;

    trigger_frame_decoder dut (
        .RD_CLK        (clk),
        .RD_RESET      (rst),
        .DIN           (din),
        .iVALID        (ivalid),
        .oREADY        (oready),
        .oSAMPLES      (osamp),
        .oSAMPLE_VALID (osv),
        .iSAMPLE_READY (isr),
        .oSAMPLE_LAST  (olast),
        .oFRAME_DONE   (odone),
        .oCHANNEL_ID   (ochan),
        .oTIME_STAMP   (ots),
        .oFRAME_LEN    (olen),
        .oFRAME_ERR    (oerr),
        .oERR_CNT      (oerrcnt),
        .oBUSY         (obusy)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Data words and their hand-unpacked samples {lane3,lane2,lane1,lane0}.
    logic [63:0] tv_word [5];
    logic [47:0] tv_samp [5];
    initial begin
        tv_word[0] = 64'h7FF0_800F_7FFA_8005; tv_samp[0] = 48'h7FF_800_7FF_800;
        tv_word[1] = 64'h8001_7FF2_8003_7FF4; tv_samp[1] = 48'h800_7FF_800_7FF;
        tv_word[2] = 64'h1230_4561_7892_ABC3; tv_samp[2] = 48'h123_456_789_ABC;
        tv_word[3] = 64'hFFFF_0000_A5A5_5A5A; tv_samp[3] = 48'hFFF_000_A5A_5A5;
        tv_word[4] = 64'h0010_0020_0030_0040; tv_samp[4] = 48'h001_002_003_004;
    end

    typedef struct packed {
        logic        err;
        logic [7:0]  ch;
        logic [47:0] ts;
        logic [7:0]  len;
    } done_t;

    logic [48:0] samp_q [$];
    logic [48:0] exp_q  [$];
    done_t       done_q [$];
    int          idx_q  [$];

    always @(negedge clk) begin
        if (!rst) begin
            if (osv && isr) samp_q.push_back({olast, osamp});
            if (odone) done_q.push_back(done_t'({oerr, ochan, ots, olen}));
        end
    end

    // Sample-ready pattern: 0 = always ready, 1 = toggle, 2 = stalled.
    int rdy_mode = 0;
    always @(posedge clk) begin
        #2;
        case (rdy_mode)
            1:       isr = ~isr;
            2:       isr = 1'b0;
            default: isr = 1'b1;
        endcase
    end

    // All stimulus steps start and end 2 time units after a rising edge.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic send(input logic [63:0] w);
        int n = 0;
        din    = w;
        ivalid = 1'b1;
        #1;
        while (!oready) begin
            if (n >= 200) begin
                check("send_ready", 64'(oready), 64'd1);
                break;
            end
            @(posedge clk);
            #3;
            n++;
        end
        @(posedge clk);
        #2;
        ivalid = 1'b0;
        din    = '0;
    endtask

    task automatic send_frame(input logic [7:0] ch, input logic [31:0] ts,
                              input logic [15:0] ts_hi, input logic [7:0] fmark,
                              input logic [7:0] fch);
        int n;
        n = idx_q.size();
        samp_q.delete();
        done_q.delete();
        exp_q.delete();
        send({8'hAA, ch, 8'(n), 8'h00, ts});
        for (int i = 0; i < n; i++) begin
            send(tv_word[idx_q[i]]);
            exp_q.push_back({(i == n - 1), tv_samp[idx_q[i]]});
        end
        send({fmark, fch, ts_hi, 32'h0});
        tick(4);
    endtask

    task automatic check_frame(input string tag, input logic [7:0] ch,
                               input logic [47:0] ts, input logic [7:0] len,
                               input logic err);
        check({tag, "_nsamp"}, 64'(samp_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < samp_q.size(); i++) begin
            check($sformatf("%s_samp%0d", tag, i), 64'(samp_q[i]), 64'(exp_q[i]));
        end
        check({tag, "_ndone"}, 64'(done_q.size()), 64'd1);
        if (done_q.size() >= 1) begin
            check({tag, "_ch"},  64'(done_q[0].ch),  64'(ch));
            check({tag, "_ts"},  64'(done_q[0].ts),  64'(ts));
            check({tag, "_len"}, 64'(done_q[0].len), 64'(len));
            check({tag, "_err"}, 64'(done_q[0].err), 64'(err));
        end
        $display("frame %s: %0d samples, %0d done pulses, err_cnt %0d",
                 tag, samp_q.size(), done_q.size(), oerrcnt);
    endtask

    initial begin
        rst    = 1'b1;
        din    = '0;
        ivalid = 1'b0;
        tick(3);

        // Reset state
        check("rst_ready",  64'(oready),  64'd0);
        check("rst_svalid", 64'(osv),     64'd0);
        check("rst_samp",   64'(osamp),   64'd0);
        check("rst_done",   64'(odone),   64'd0);
        check("rst_ts",     64'(ots),     64'd0);
        check("rst_errcnt", 64'(oerrcnt), 64'd0);
        check("rst_busy",   64'(obusy),   64'd0);
        rst = 1'b0;
        tick(2);
        check("idle_ready", 64'(oready), 64'd1);

        // Nominal frame
        idx_q = '{0, 1, 0};
        send_frame(8'h00, 32'h1234_5678, 16'h0001, 8'h55, 8'h00);
        check_frame("nominal", 8'h00, 48'h0001_1234_5678, 8'd3, 1'b0);
        check("nominal_errcnt", 64'(oerrcnt), 64'd0);
        tick(5);
        check("meta_hold_ts", 64'(ots),   64'h0001_1234_5678);
        check("meta_hold_done", 64'(odone), 64'd0);
        check("nominal_busy", 64'(obusy), 64'd0);

        // Backpressure: stall for 5 cycles while the third sample is held
        idx_q = '{2, 3, 4, 0};
        fork
            send_frame(8'h05, 32'hDEAD_BEEF, 16'hCAFE, 8'h55, 8'h05);
            begin
                int n = 0;
                while (samp_q.size() < 1 && n < 50) begin
                    @(posedge clk);
                    #3;
                    n++;
                end
                check("stall_start", 64'(samp_q.size()), 64'd1);
                rdy_mode = 2;
                @(posedge clk);
                #3;
                for (int c = 0; c < 5; c++) begin
                    @(negedge clk);
                    check($sformatf("stall_ready%0d", c), 64'(oready), 64'd0);
                    check($sformatf("stall_samp%0d", c),  64'(osamp),  64'(tv_samp[4]));
                    check($sformatf("stall_valid%0d", c), 64'(osv),    64'd1);
                end
                rdy_mode = 0;
            end
        join
        check_frame("stall", 8'h05, 48'hCAFE_DEAD_BEEF, 8'd4, 1'b0);

        // Sample-ready toggling every cycle
        rdy_mode = 1;
        idx_q = '{4, 3, 2, 1, 0};
        send_frame(8'h07, 32'h0000_0100, 16'h0002, 8'h55, 8'h07);
        rdy_mode = 0;
        tick(3);
        check_frame("toggle", 8'h07, 48'h0002_0000_0100, 8'd5, 1'b0);

        // Garbage before a header
        send(64'h0123_4567_89AB_CDEF);
        send(64'h5500_0001_0000_0000);
        tick(1);
        check("garbage_errcnt", 64'(oerrcnt), 64'd2);
        check("garbage_busy",   64'(obusy),   64'd0);
        idx_q = '{2};
        send_frame(8'h03, 32'hA5A5_A5A5, 16'h5A5A, 8'h55, 8'h03);
        check_frame("after_garbage", 8'h03, 48'h5A5A_A5A5_A5A5, 8'd1, 1'b0);

        // Bad footer marker, then footer with the wrong channel
        idx_q = '{0, 1};
        send_frame(8'h09, 32'h0000_0001, 16'h0003, 8'h00, 8'h09);
        check_frame("bad_marker", 8'h09, 48'h0003_0000_0001, 8'd2, 1'b1);
        check("bad_marker_errcnt", 64'(oerrcnt), 64'd3);
        send_frame(8'h0A, 32'h0000_0002, 16'h0004, 8'h55, 8'h0B);
        check_frame("bad_chan", 8'h0A, 48'h0004_0000_0002, 8'd2, 1'b1);
        check("bad_chan_errcnt", 64'(oerrcnt), 64'd4);
        idx_q = '{3, 2, 1};
        send_frame(8'h01, 32'h0000_0003, 16'h0005, 8'h55, 8'h01);
        check_frame("recover", 8'h01, 48'h0005_0000_0003, 8'd3, 1'b0);
        check("recover_errcnt", 64'(oerrcnt), 64'd4);

        // Header LEN out of range
        send({8'hAA, 8'h00, 8'd0, 8'h00, 32'h0});
        tick(1);
        check("len0_errcnt", 64'(oerrcnt), 64'd5);
        check("len0_busy",   64'(obusy),   64'd0);
        send({8'hAA, 8'h00, 8'd51, 8'h00, 32'h0});
        tick(1);
        check("len51_errcnt", 64'(oerrcnt), 64'd6);
        check("len51_busy",   64'(obusy),   64'd0);

        // Longest legal frame
        idx_q.delete();
        for (int i = 0; i < 50; i++) idx_q.push_back(i % 5);
        send_frame(8'h32, 32'h5050_5050, 16'h0050, 8'h55, 8'h32);
        check_frame("len50", 8'h32, 48'h0050_5050_5050, 8'd50, 1'b0);
        check("len50_errcnt", 64'(oerrcnt), 64'd6);

        // Reset after the second data word
        samp_q.delete();
        done_q.delete();
        send({8'hAA, 8'h02, 8'd4, 8'h00, 32'h9999_9999});
        send(tv_word[0]);
        send(tv_word[1]);
        rst = 1'b1;
        tick(2);
        check("midrst_svalid", 64'(osv),     64'd0);
        check("midrst_samp",   64'(osamp),   64'd0);
        check("midrst_ts",     64'(ots),     64'd0);
        check("midrst_len",    64'(olen),    64'd0);
        check("midrst_errcnt", 64'(oerrcnt), 64'd0);
        check("midrst_busy",   64'(obusy),   64'd0);
        rst = 1'b0;
        tick(3);
        check("midrst_ndone", 64'(done_q.size()), 64'd0);
        check("midrst_idle",  64'(obusy),         64'd0);
        idx_q = '{0, 1, 2, 3};
        send_frame(8'h02, 32'h1122_3344, 16'h5566, 8'h55, 8'h02);
        check_frame("post_rst", 8'h02, 48'h5566_1122_3344, 8'd4, 1'b0);
        check("post_rst_errcnt", 64'(oerrcnt), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/trigger_frame_decoder.md
Name: trigger_frame_decoder

Overview:
Read-out-side consumer of the 64-bit triggered-frame stream that the trigger block emits on DOUT/oVALID/iREADY in the RD_CLK domain. It parses each frame (header, data words, footer), unpacks the data words into ADC samples with a valid/ready output, and reports per-frame metadata and errors. It sits between the trigger block's read port and downstream storage or DMA logic.

Parameters:
DIN_WIDTH, 64, frame word width (fixed, 64 only)
ADC_RESOLUTION_WIDTH, 12, sample width; sample sits in lane bits [15 -: ADC_RESOLUTION_WIDTH]
SAMPLE_PER_WORD, 4, 16-bit lanes per word (DIN_WIDTH/16)
TIME_STAMP_WIDTH, 48, full timestamp width
FIRST_TIME_STAMP_WIDTH, 32, timestamp bits carried in header
MAX_FRAME_LENGTH, 50, max data words per frame
HEADER_ID, 8'hAA, header marker
FOOTER_ID, 8'h55, footer marker

Ports:
RD_CLK  in  1  clock
RD_RESET  in  1  synchronous active-high reset
DIN  in  64  frame word from trigger block
iVALID  in  1  DIN valid
oREADY  out  1  decoder accepts DIN
oSAMPLES  out  48  4 samples; lane k at [12k+11:12k], lane 0 = DIN[15:4]
oSAMPLE_VALID  out  1  oSAMPLES valid
iSAMPLE_READY  in  1  downstream accepts samples
oSAMPLE_LAST  out  1  last data word of frame
oFRAME_DONE  out  1  1-cycle pulse at footer acceptance
oCHANNEL_ID  out  8  channel of completed frame
oTIME_STAMP  out  48  {footer ts[47:32], header ts[31:0]}
oFRAME_LEN  out  8  data words received
oFRAME_ERR  out  1  completed frame had error (valid with oFRAME_DONE)
oERR_CNT  out  16  saturating error count
oBUSY  out  1  state != IDLE

Behaviour:
- Frame format. Header: [63:56]=HEADER_ID, [55:48]=channel, [47:40]=LEN (data words), [39:32]=0, [31:0]=ts[31:0]. LEN data words follow. Footer: [63:56]=FOOTER_ID, [55:48]=channel, [47:32]=ts[47:32], [31:0]=0.
- Transfer occurs when iVALID & oREADY.
- oREADY is combinational: 0 while RD_RESET; else 1 in IDLE and FOOTER; in DATA = !oSAMPLE_VALID | iSAMPLE_READY.
- State machine:
  - IDLE: wait for a transfer.
    - Word with [63:56]==HEADER_ID and 1<=LEN<=MAX_FRAME_LENGTH: latch channel, LEN, ts low; clear word count; go to DATA.
    - Any other word: drop it, increment oERR_CNT, stay in IDLE. A header with bad LEN is dropped the same way.
  - DATA: each transfer loads oSAMPLES from the lane MSBs and sets oSAMPLE_VALID the next cycle (latency 1). oSAMPLE_LAST=1 on word LEN. After word LEN, go to FOOTER. Data words are not checked for markers.
  - FOOTER: the next transfer is the footer.
    - Marker==FOOTER_ID and channel matches: oFRAME_ERR=0.
    - Otherwise: oFRAME_ERR=1 and oERR_CNT+1.
    - In both cases: pulse oFRAME_DONE the next cycle with oCHANNEL_ID (header value), oTIME_STAMP, oFRAME_LEN; return to IDLE.
- oSAMPLE_VALID holds with data stable until iSAMPLE_READY. It clears when iSAMPLE_READY is high and no new word is accepted in the same cycle. Accept and drain in the same cycle replace the data with no bubble.
- Metadata outputs hold their value until the next oFRAME_DONE.
- oERR_CNT saturates at 16'hFFFF. It increments at most once per cycle.
- Reset values: all outputs 0, state IDLE, counters 0.
- Reset mid-frame returns to IDLE with no oFRAME_DONE. Any pending sample is discarded.
- iVALID low mid-frame: wait indefinitely, no timeout.

Test Plan:
- Nominal: header(ch=0, LEN=3, ts=32'h12345678), 3 data words with lane samples 0x800/0x7FF, footer(ch=0, ts_hi=16'h0001), iSAMPLE_READY=1 -> 3 oSAMPLE_VALID cycles with correct unpacking, oSAMPLE_LAST on the 3rd; oFRAME_DONE with oTIME_STAMP=48'h000112345678, oFRAME_LEN=3, oFRAME_ERR=0.
- Backpressure: iSAMPLE_READY low 5 cycles mid-frame -> oREADY=0, oSAMPLES stable, no loss; toggle iSAMPLE_READY every cycle -> all LEN words delivered in order.
- Garbage before header: 2 non-header words, then a valid frame -> oERR_CNT=2, frame decoded normally.
- Bad footer: footer marker 8'h00 -> oFRAME_DONE with oFRAME_ERR=1, oERR_CNT+1, next frame decoded.
- Bad LEN: header LEN=0 and LEN=51 -> each dropped, oERR_CNT+1 each, state stays IDLE.
- Reset mid-frame: assert RD_RESET after data word 2 -> all outputs 0, no oFRAME_DONE; the next full frame decodes correctly.
